// File: rtl/leitor_teclado.sv
// leitor_teclado: 4x3 matrix keypad scanner with debouncing.
// Drives one keypad column low at a time, looks for exactly one low row,
// debounces the press, emits the key code with a one-cycle strobe, then
// waits for a debounced release before scanning again.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   linhas   in   [3:0] keypad rows, active-low (1111 = no key)
//   colunas  out  [2:0] column drive, active-low one-hot
//   numero   out  [3:0] code of the last accepted key (* = 10, # = 11)
//   insere   out  one-cycle strobe: numero is new and valid
//   ocupado  out  high while a key is being debounced, emitted or released
module leitor_teclado #(
    parameter int unsigned SCAN_CYCLES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] linhas,
    output logic [2:0] colunas,
    output logic [3:0] numero,
    output logic       insere,
    output logic       ocupado
);

    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        VARRE,
        ESTABILIZA,
        EMITE,
        ESPERA_SOLTAR
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q,   cnt_d;
    logic [2:0]    col_q,   col_d;
    logic [3:0]    rows_q,  rows_d;
    logic [3:0]    numero_q, numero_d;
    logic          insere_q, insere_d;
    logic          ocupado_q;
    logic          one_low;
    logic [2:0]    col_next;

    // Row r / column c -> key code; row 3 holds *, 0, #.
    function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [2:0] cols);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
        case (rows)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case (cols)
            3'b110:  c = 2'd0;
            3'b101:  c = 2'd1;
            default: c = 2'd2;
        endcase
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = 4'd10;
                2'd1:    code = 4'd0;
                default: code = 4'd11;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

    // Only a single low row is a valid press; zero or several are ignored.
    always_comb begin
        case (linhas)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    end

    // Rotate the low bit: 110 -> 101 -> 011 -> 110.
    assign col_next = {col_q[1:0], col_q[2]};

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        rows_d   = rows_q;
        numero_d = numero_q;
        insere_d = 1'b0;

        case (state_q)
            VARRE: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (one_low) begin
                        rows_d  = linhas;
                        cnt_d   = '0;
                        state_d = ESTABILIZA;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ESTABILIZA: begin
                if (linhas == rows_q) begin
                    // Transition on the sample that brings the count to DEBOUNCE_CYCLES.
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        state_d = EMITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    col_d   = col_next;
                    dwell_d = '0;
                    state_d = VARRE;
                end
            end
            EMITE: begin
                numero_d = key_code(rows_q, col_q);
                insere_d = 1'b1;
                cnt_d    = '0;
                state_d  = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (linhas == 4'b1111) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        col_d   = 3'b110;
                        dwell_d = '0;
                        state_d = VARRE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = VARRE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= VARRE;
            dwell_q   <= '0;
            cnt_q     <= '0;
            col_q     <= 3'b110;
            rows_q    <= '1;
            numero_q  <= '0;
            insere_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            rows_q    <= rows_d;
            numero_q  <= numero_d;
            insere_q  <= insere_d;
            ocupado_q <= (state_d != VARRE);
        end
    end

    assign colunas = col_q;
    assign numero  = numero_q;
    assign insere  = insere_q;
    assign ocupado = ocupado_q;

endmodule

// File: tb/tb_leitor_teclado.sv
// tb_leitor_teclado: self-checking bench for leitor_teclado.
// A keypad model turns a mask of pressed keys into row levels from the
// driven columns; expected key codes are queued when a press starts and
// popped by a monitor whenever insere is seen.
module tb_leitor_teclado;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] linhas;
    logic [2:0] colunas;
    logic [3:0] numero;
    logic       insere;
    logic       ocupado;

    logic [11:0] key_mask = '0;   // bit r*3+c = key at row r, column c held
    logic [3:0]  exp_q[$];
    int          errors  = 0;
    int          checks  = 0;
    int          strobes = 0;
    logic        prev_ins = 1'b0;

    // Expected code for key index r*3+c.
    int code_tab[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    leitor_teclado #(
        .SCAN_CYCLES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .linhas  (linhas),
        .colunas (colunas),
        .numero  (numero),
        .insere  (insere),
        .ocupado (ocupado)
    );

    always #5 clk = ~clk;

    // Keypad: a row is pulled low if any held key in it sits on a driven column.
    always_comb begin
        linhas = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (key_mask[r*3+c] && !colunas[c]) linhas[r] = 1'b0;
            end
        end
    end

    // Strobe monitor / scoreboard consumer.
    always @(negedge clk) begin
        logic [3:0] e;
        if (insere === 1'b1) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: numero=%0d, no strobe expected", numero);
            end else begin
                e = exp_q.pop_front();
                if (numero !== e) begin
                    errors++;
                    $display("FAIL strobe_numero: got %0d, expected %0d", numero, e);
                end
            end
            if (prev_ins === 1'b1) begin
                errors++;
                $display("FAIL insere_back_to_back: insere=1 two cycles in a row, expected single pulse");
            end
        end
        prev_ins = insere;
    end

    // Leaves the bench at the negedge of the first cycle after reset (scan cycle 0).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits until the scanner is back in VARRE; returns at scan cycle 0.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (ocupado !== 1'b0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle_timeout: ocupado=%b, expected 0 within 80 cycles", ocupado);
        end
    endtask

    // Clean press: hold until strobe plus 20 cycles, release, wait for idle.
    task automatic press_key(input int idx);
        int s0 = strobes;
        int n  = 0;
        key_mask = 12'(1) << idx;
        exp_q.push_back(4'(code_tab[idx]));
        @(negedge clk);
        while (insere !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (insere !== 1'b1) begin
            errors++;
            $display("FAIL press_timeout key%0d: insere=%b, expected 1 within 60 cycles", idx, insere);
        end
        repeat (20) @(negedge clk);
        key_mask = '0;
        wait_idle();
        checks++;
        if (strobes !== s0 + 1) begin
            errors++;
            $display("FAIL press_strobe_count key%0d: got %0d strobes, expected 1", idx, strobes - s0);
        end
    endtask

    task automatic test_reset();
        logic [2:0] seq[3] = '{3'b110, 3'b101, 3'b011};
        int bad = 0;
        key_mask = '0;
        do_reset();
        checks += 4;
        if (colunas !== 3'b110) begin errors++; $display("FAIL reset_colunas: got %b, expected 110", colunas); end
        if (numero  !== 4'd0)   begin errors++; $display("FAIL reset_numero: got %0d, expected 0", numero); end
        if (insere  !== 1'b0)   begin errors++; $display("FAIL reset_insere: got %b, expected 0", insere); end
        if (ocupado !== 1'b0)   begin errors++; $display("FAIL reset_ocupado: got %b, expected 0", ocupado); end
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (colunas !== seq[(k/2)%3]) begin
                errors++;
                $display("FAIL idle_scan k=%0d: colunas=%b, expected %b", k, colunas, seq[(k/2)%3]);
            end
            if (insere !== 1'b0 || numero !== 4'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_outputs: %0d cycles with insere/numero nonzero, expected 0", bad);
        end
    endtask

    task automatic test_key5();
        int s0;
        do_reset();
        s0 = strobes;
        key_mask = 12'(1) << 4;
        exp_q.push_back(4'd5);
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 20) key_mask = '0;
            if (k == 3) begin checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL key5_ocupado_pre: got %b, expected 0", ocupado); end end
            if (k == 4) begin checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL key5_ocupado_detect: got %b, expected 1", ocupado); end end
            if (k == 8) begin checks++; if (insere !== 1'b0) begin errors++; $display("FAIL key5_early: insere=%b, expected 0", insere); end end
            if (k == 9) begin checks++; if (insere !== 1'b1) begin errors++; $display("FAIL key5_latency: insere=%b, expected 1", insere); end end
            if (k == 23) begin checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL key5_release_busy: ocupado=%b, expected 1", ocupado); end end
            if (k == 24) begin
                checks += 2;
                if (ocupado !== 1'b0) begin errors++; $display("FAIL key5_release_idle: ocupado=%b, expected 0", ocupado); end
                if (colunas !== 3'b110) begin errors++; $display("FAIL key5_release_col: colunas=%b, expected 110", colunas); end
            end
        end
        checks++;
        if (strobes !== s0 + 1) begin
            errors++;
            $display("FAIL key5_count: got %0d strobes, expected 1", strobes - s0);
        end
    endtask

    task automatic test_bounce();
        int s0;
        do_reset();
        s0 = strobes;
        key_mask = 12'(1) << 7;
        exp_q.push_back(4'd8);
        for (int k = 0; k <= 19; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 6) key_mask = '0;
            if (k == 7) begin
                key_mask = 12'(1) << 7;
                checks++;
                if (ocupado !== 1'b0) begin errors++; $display("FAIL bounce_abort: ocupado=%b, expected 0", ocupado); end
            end
            if (k == 17) begin checks++; if (strobes !== s0) begin errors++; $display("FAIL bounce_early_strobe: got %0d strobes, expected 0", strobes - s0); end end
            if (k == 18) begin checks++; if (insere !== 1'b1) begin errors++; $display("FAIL bounce_retry: insere=%b, expected 1", insere); end end
        end
        key_mask = '0;
        wait_idle();
    endtask

    task automatic test_sequence();
        int keys[6] = '{4, 7, 8, 1, 10, 3};
        foreach (keys[i]) press_key(keys[i]);
        repeat (10) @(negedge clk);
        checks++;
        if (numero !== 4'd4) begin
            errors++;
            $display("FAIL seq_hold: numero=%0d, expected 4", numero);
        end
    endtask

    task automatic test_special();
        int s0;
        int busy = 0;
        press_key(9);
        press_key(11);
        s0 = strobes;
        key_mask = 12'b0000_0000_1001;   // keys 1 and 4 together
        repeat (40) begin
            @(negedge clk);
            if (ocupado !== 1'b0) busy++;
        end
        key_mask = '0;
        checks += 2;
        if (busy !== 0) begin errors++; $display("FAIL multi_busy: %0d busy cycles, expected 0", busy); end
        if (strobes !== s0) begin errors++; $display("FAIL multi_strobe: got %0d strobes, expected 0", strobes - s0); end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        checks += 4;
        if (colunas !== 3'b110) begin errors++; $display("FAIL %s_colunas: got %b, expected 110", tag, colunas); end
        if (numero  !== 4'd0)   begin errors++; $display("FAIL %s_numero: got %0d, expected 0", tag, numero); end
        if (insere  !== 1'b0)   begin errors++; $display("FAIL %s_insere: got %b, expected 0", tag, insere); end
        if (ocupado !== 1'b0)   begin errors++; $display("FAIL %s_ocupado: got %b, expected 0", tag, ocupado); end
    endtask

    task automatic test_reset_abort();
        int s0;
        // Reset during ESTABILIZA.
        press_key(2);
        key_mask = 12'(1) << 4;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (ocupado !== 1'b1) begin errors++; $display("FAIL abort1_busy: ocupado=%b, expected 1", ocupado); end
                reset = 1'b1;
            end
        end
        check_reset_vals("abort1");
        reset = 1'b0;
        key_mask = '0;
        s0 = strobes;
        repeat (30) @(negedge clk);
        checks++;
        if (strobes !== s0) begin errors++; $display("FAIL abort1_strobe: got %0d strobes, expected 0", strobes - s0); end

        // Reset in the cycle EMITE is entered.
        press_key(8);
        key_mask = 12'(1) << 4;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) begin
                checks += 2;
                if (ocupado !== 1'b1) begin errors++; $display("FAIL abort2_busy: ocupado=%b, expected 1", ocupado); end
                if (insere !== 1'b0) begin errors++; $display("FAIL abort2_pre: insere=%b, expected 0", insere); end
                reset = 1'b1;
            end
        end
        check_reset_vals("abort2");
        reset = 1'b0;
        key_mask = '0;
        s0 = strobes;
        repeat (30) @(negedge clk);
        checks++;
        if (strobes !== s0) begin errors++; $display("FAIL abort2_strobe: got %0d strobes, expected 0", strobes - s0); end
    endtask

    initial begin
        test_reset();
        test_key5();
        test_bounce();
        test_sequence();
        test_special();
        test_reset_abort();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pending_strobes: %0d expected strobes never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
